// File: rtl/rvfi_retire_emitter.sv
// rvfi_retire_emitter: in-order FIFO that normalises core retirement records and emits them on the RVFI bus, one per cycle, with a registered output.
// Optional feature macro RVFI_EMIT_HOLD_EN: when defined, emit_hold stalls emission for that cycle.
module rvfi_retire_emitter #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_insn,
  input  logic [4:0]                 in_rs1_addr,
  input  logic [4:0]                 in_rs2_addr,
  input  logic [4:0]                 in_rd,
  input  logic [XLEN-1:0]            in_pre_pc,
  input  logic [XLEN-1:0]            in_pre_rs1,
  input  logic [XLEN-1:0]            in_pre_rs2,
  input  logic [XLEN-1:0]            in_post_pc,
  input  logic [XLEN-1:0]            in_post_rd,
  input  logic                       in_trap,
  input  logic [XLEN-1:0]            in_mem_addr,
  input  logic [XLEN-1:0]            in_mem_rdata,
  input  logic [XLEN-1:0]            in_mem_wdata,
  input  logic [XLEN/8-1:0]          in_mem_rmask,
  input  logic [XLEN/8-1:0]          in_mem_wmask,
  input  logic                       emit_hold,
  output logic                       rvfi_valid,
  output logic [7:0]                 rvfi_order,
  output logic [31:0]                rvfi_insn,
  output logic [4:0]                 rvfi_rs1_addr,
  output logic [4:0]                 rvfi_rs2_addr,
  output logic [4:0]                 rvfi_rd,
  output logic [XLEN-1:0]            rvfi_pre_pc,
  output logic [XLEN-1:0]            rvfi_pre_rs1,
  output logic [XLEN-1:0]            rvfi_pre_rs2,
  output logic [XLEN-1:0]            rvfi_post_pc,
  output logic [XLEN-1:0]            rvfi_post_rd,
  output logic                       rvfi_trap,
  output logic [XLEN-1:0]            rvfi_mem_addr,
  output logic [XLEN/8-1:0]          rvfi_mem_rmask,
  output logic [XLEN/8-1:0]          rvfi_mem_wmask,
  output logic [XLEN-1:0]            rvfi_mem_rdata,
  output logic [XLEN-1:0]            rvfi_mem_wdata,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int MW = XLEN / 8;

  typedef struct packed {
    logic [31:0]     insn;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [4:0]      rd;
    logic [XLEN-1:0] pre_pc;
    logic [XLEN-1:0] pre_rs1;
    logic [XLEN-1:0] pre_rs2;
    logic [XLEN-1:0] post_pc;
    logic [XLEN-1:0] post_rd;
    logic            trap;
    logic [XLEN-1:0] mem_addr;
    logic [MW-1:0]   mem_rmask;
    logic [MW-1:0]   mem_wmask;
    logic [XLEN-1:0] mem_rdata;
    logic [XLEN-1:0] mem_wdata;
  } rec_t;

  rec_t          mem [DEPTH];
  rec_t          wr_rec;
  rec_t          out_rec;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] cnt;
  logic [7:0]    ord;
  logic          live;
  logic          hold;
  logic          push;
  logic          pop;

`ifdef RVFI_EMIT_HOLD_EN
  assign hold = emit_hold;
`else
  assign hold = 1'b0 & emit_hold;
`endif

  // live goes high on the first edge after reset release so in_ready stays low during reset
  assign in_ready = live && (cnt != CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (cnt != '0) && !hold;
  assign count    = cnt;

  // trapped instructions carry no register write or memory access; x0 writes carry no data
  always_comb begin
    wr_rec           = '0;
    wr_rec.insn      = in_insn;
    wr_rec.rs1_addr  = in_rs1_addr;
    wr_rec.rs2_addr  = in_rs2_addr;
    wr_rec.rd        = in_trap ? 5'd0 : in_rd;
    wr_rec.pre_pc    = in_pre_pc;
    wr_rec.pre_rs1   = in_pre_rs1;
    wr_rec.pre_rs2   = in_pre_rs2;
    wr_rec.post_pc   = in_post_pc;
    wr_rec.post_rd   = (in_trap || in_rd == 5'd0) ? '0 : in_post_rd;
    wr_rec.trap      = in_trap;
    wr_rec.mem_addr  = in_trap ? '0 : in_mem_addr;
    wr_rec.mem_rmask = in_trap ? '0 : in_mem_rmask;
    wr_rec.mem_wmask = in_trap ? '0 : in_mem_wmask;
    wr_rec.mem_rdata = in_trap ? '0 : in_mem_rdata;
    wr_rec.mem_wdata = in_trap ? '0 : in_mem_wdata;
  end

  // record storage needs no reset: occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= wr_rec;
  end

  // pointers, occupancy, order counter and the registered RVFI output stage
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      live       <= 1'b0;
      head       <= '0;
      tail       <= '0;
      cnt        <= '0;
      ord        <= '0;
      out_rec    <= '0;
      rvfi_valid <= 1'b0;
      rvfi_order <= '0;
    end else begin
      live       <= 1'b1;
      if (push) tail <= tail + 1'b1;
      if (pop) head <= head + 1'b1;
      if (pop) ord <= ord + 8'd1;
      cnt        <= cnt + CW'(push) - CW'(pop);
      out_rec    <= pop ? mem[head] : '0;
      rvfi_valid <= pop;
      rvfi_order <= pop ? ord : 8'd0;
    end
  end

  assign rvfi_insn      = out_rec.insn;
  assign rvfi_rs1_addr  = out_rec.rs1_addr;
  assign rvfi_rs2_addr  = out_rec.rs2_addr;
  assign rvfi_rd        = out_rec.rd;
  assign rvfi_pre_pc    = out_rec.pre_pc;
  assign rvfi_pre_rs1   = out_rec.pre_rs1;
  assign rvfi_pre_rs2   = out_rec.pre_rs2;
  assign rvfi_post_pc   = out_rec.post_pc;
  assign rvfi_post_rd   = out_rec.post_rd;
  assign rvfi_trap      = out_rec.trap;
  assign rvfi_mem_addr  = out_rec.mem_addr;
  assign rvfi_mem_rmask = out_rec.mem_rmask;
  assign rvfi_mem_wmask = out_rec.mem_wmask;
  assign rvfi_mem_rdata = out_rec.mem_rdata;
  assign rvfi_mem_wdata = out_rec.mem_wdata;
endmodule

// File: tb/tb_rvfi_retire_emitter.sv
// tb_rvfi_retire_emitter: scoreboard bench for rvfi_retire_emitter (XLEN=32, DEPTH=4); hold tests run when RVFI_EMIT_HOLD_EN is defined.
module tb_rvfi_retire_emitter;
  typedef struct packed {
    logic [31:0] insn;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] pre_pc;
    logic [31:0] pre_rs1;
    logic [31:0] pre_rs2;
    logic [31:0] post_pc;
    logic [31:0] post_rd;
    logic        trap;
    logic [31:0] maddr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] rdata;
    logic [31:0] wdata;
  } rec_t;

  logic clk = 1'b0, resetn = 1'b0, in_valid = 1'b0, in_ready, emit_hold = 1'b0;
  rec_t in_r = '0;
  logic rvfi_valid, rvfi_trap;
  logic [7:0] rvfi_order;
  logic [31:0] rvfi_insn, rvfi_pre_pc, rvfi_pre_rs1, rvfi_pre_rs2, rvfi_post_pc, rvfi_post_rd;
  logic [31:0] rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;
  logic [4:0] rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd;
  logic [3:0] rvfi_mem_rmask, rvfi_mem_wmask;
  logic [2:0] count;

  int tests = 0, fails = 0, cyc = 0, n_emit = 0, first_cyc = 0, last_cyc = 0;
  logic [7:0] exp_ord = 8'd0;
  rec_t q[$];

  rvfi_retire_emitter #(.XLEN(32), .DEPTH(4)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_insn(in_r.insn), .in_rs1_addr(in_r.rs1), .in_rs2_addr(in_r.rs2), .in_rd(in_r.rd),
    .in_pre_pc(in_r.pre_pc), .in_pre_rs1(in_r.pre_rs1), .in_pre_rs2(in_r.pre_rs2),
    .in_post_pc(in_r.post_pc), .in_post_rd(in_r.post_rd), .in_trap(in_r.trap),
    .in_mem_addr(in_r.maddr), .in_mem_rdata(in_r.rdata), .in_mem_wdata(in_r.wdata),
    .in_mem_rmask(in_r.rmask), .in_mem_wmask(in_r.wmask), .emit_hold(emit_hold),
    .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
    .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr), .rvfi_rd(rvfi_rd),
    .rvfi_pre_pc(rvfi_pre_pc), .rvfi_pre_rs1(rvfi_pre_rs1), .rvfi_pre_rs2(rvfi_pre_rs2),
    .rvfi_post_pc(rvfi_post_pc), .rvfi_post_rd(rvfi_post_rd), .rvfi_trap(rvfi_trap),
    .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
    .rvfi_mem_rdata(rvfi_mem_rdata), .rvfi_mem_wdata(rvfi_mem_wdata), .count(count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic rec_t norm(input rec_t r);
    rec_t n = r;
    if (r.rd == 5'd0) n.post_rd = '0;
    if (r.trap) begin
      n.rd = '0; n.post_rd = '0; n.rmask = '0; n.wmask = '0;
      n.maddr = '0; n.wdata = '0; n.rdata = '0;
    end
    return n;
  endfunction

  function automatic rec_t rnd_rec();
    rec_t r;
    r.insn = $urandom; r.rs1 = 5'($urandom); r.rs2 = 5'($urandom); r.rd = 5'($urandom);
    r.pre_pc = $urandom; r.pre_rs1 = $urandom; r.pre_rs2 = $urandom;
    r.post_pc = r.pre_pc + 32'd4; r.post_rd = $urandom; r.trap = ($urandom_range(0, 7) == 0);
    r.maddr = $urandom; r.rmask = 4'($urandom); r.wmask = 4'($urandom);
    r.rdata = $urandom; r.wdata = $urandom;
    return r;
  endfunction

  // called at posedge+1: offers r for the coming edge, returns at posedge+1 after it
  task automatic send(input rec_t r);
    in_r = r;
    in_valid = 1'b1;
    check("ready", in_ready, 1'b1);
    if (in_ready) q.push_back(norm(r));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #1;
    check("rst_valid", rvfi_valid, 1'b0);
    check("rst_count", count, 3'd0);
    check("rst_ready", in_ready, 1'b0);
    q.delete();
    exp_ord = 8'd0;
    n_emit = 0;
    emit_hold = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", in_ready, 1'b1);
  endtask

  // scoreboard side: every emitted record must match the oldest outstanding expectation
  always @(negedge clk) begin
    logic [311:0] got;
    rec_t e;
    got = {rvfi_insn, rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd, rvfi_pre_pc, rvfi_pre_rs1,
           rvfi_pre_rs2, rvfi_post_pc, rvfi_post_rd, rvfi_trap, rvfi_mem_addr,
           rvfi_mem_rmask, rvfi_mem_wmask, rvfi_mem_rdata, rvfi_mem_wdata};
    if (rvfi_valid) begin
      if (q.size() == 0) check("spurious_emit", 1'b1, 1'b0);
      else begin
        e = q.pop_front();
        check("record", got, e);
        check("order", rvfi_order, exp_ord);
      end
      exp_ord++;
      if (n_emit == 0) first_cyc = cyc;
      last_cyc = cyc;
      n_emit++;
    end else check("idle_zero", {rvfi_order, got}, '0);
  end

  initial begin
    rec_t r;
    #12;
    check("rst_ready0", in_ready, 1'b0);
    check("rst_valid0", rvfi_valid, 1'b0);
    check("rst_count0", count, 3'd0);
    do_reset();

    r = '0;
    r.insn = 32'h00500093; r.rd = 5'd1; r.post_rd = 32'd5;
    r.pre_pc = 32'h0000_1000; r.post_pc = 32'h0000_1004;
    send(r);
    check("lat_valid0", rvfi_valid, 1'b0);
    check("lat_count1", count, 3'd1);
    idle(1);
    check("lat_valid1", rvfi_valid, 1'b1);
    check("lat_order0", rvfi_order, 8'd0);
    check("lat_insn", rvfi_insn, 32'h00500093);
    check("lat_post_rd", rvfi_post_rd, 32'd5);
    check("lat_post_pc", rvfi_post_pc, 32'h0000_1004);
    idle(1);
    check("lat_valid_off", rvfi_valid, 1'b0);
    check("lat_insn_off", rvfi_insn, 32'd0);

    r = rnd_rec(); r.rd = 5'd0; r.post_rd = 32'hDEADBEEF; r.trap = 1'b0;
    send(r);
    r = rnd_rec(); r.trap = 1'b1; r.rd = 5'd3; r.wmask = 4'hF; r.maddr = 32'h80;
    send(r);
    check("x0_post_rd", rvfi_post_rd, 32'd0);
    idle(1);
    check("trap_flag", rvfi_trap, 1'b1);
    check("trap_rd", rvfi_rd, 5'd0);
    check("trap_wmask", rvfi_mem_wmask, 4'h0);
    check("trap_addr", rvfi_mem_addr, 32'd0);
    idle(2);

`ifdef RVFI_EMIT_HOLD_EN
    do_reset();
    emit_hold = 1'b1;
    for (int i = 0; i < 4; i++) send(rnd_rec());
    r = rnd_rec();
    in_r = r;
    in_valid = 1'b1;
    check("full_ready", in_ready, 1'b0);
    check("full_count", count, 3'd4);
    emit_hold = 1'b0;
    @(posedge clk); #1;
    check("ready_after_pop", in_ready, 1'b1);
    q.push_back(norm(r));
    @(posedge clk); #1;
    in_valid = 1'b0;
    idle(6);
    check("hold_emitted", 32'(n_emit), 32'd5);

    do_reset();
    emit_hold = 1'b1;
    for (int i = 0; i < 3; i++) send(rnd_rec());
    check("pre_rst_count", count, 3'd3);
`else
    send(rnd_rec());
    send(rnd_rec());
`endif
    do_reset();
    idle(3);
    send(rnd_rec());
    idle(2);
    check("post_rst_emits", 32'(n_emit), 32'd1);

    do_reset();
    for (int i = 0; i < 300; i++) send(rnd_rec());
    idle(3);
    check("stream_count", 32'(n_emit), 32'd300);
    check("stream_no_gap", 32'(last_cyc - first_cyc), 32'd299);
    check("stream_wrap", exp_ord, 8'd44);
    check("stream_drained", 32'(q.size()), 32'd0);

`ifndef RVFI_EMIT_HOLD_EN
    do_reset();
    for (int i = 0; i < 20; i++) begin
      emit_hold = 1'($urandom);
      send(rnd_rec());
    end
    emit_hold = 1'b0;
    idle(3);
    check("hold_ignored_count", 32'(n_emit), 32'd20);
    check("hold_ignored_gap", 32'(last_cyc - first_cyc), 32'd19);
`endif
    check("final_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
